// File: rtl/sub_mw_seq.sv
// Word-serial multi-precision subtractor: D = A - B - bin, least-significant word first,
// with the borrow chained between words and full-width Bout/Z/N/V flags on the last word.
module sub_mw_seq #(
  parameter int WIDTH = 32,
  parameter int WORDS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_last,
  output logic             out_bout,
  output logic             out_z,
  output logic             out_n,
  output logic             out_v
);

  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  logic [IDX_W-1:0] idx;
  logic             br;
  logic             zacc;

  logic             accept;
  logic             first;
  logic             last;
  logic             bi;
  logic             b_out;
  logic [WIDTH-1:0] d;
  logic             zcur;

  // The output register frees up in the same cycle it is consumed.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    first      = (idx == '0);
    last       = (idx == LAST_IDX);
    bi         = first ? in_bin : br;
    {b_out, d} = {1'b0, in_a} - {1'b0, in_b} - {{WIDTH{1'b0}}, bi};
    zcur       = (first || zacc) && (d == '0);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      br        <= 1'b0;
      zacc      <= 1'b1;
      out_valid <= 1'b0;
      out_diff  <= '0;
      out_last  <= 1'b0;
      out_bout  <= 1'b0;
      out_z     <= 1'b0;
      out_n     <= 1'b0;
      out_v     <= 1'b0;
    end else if (accept) begin
      idx       <= last ? '0 : idx + IDX_W'(1);
      br        <= b_out;
      zacc      <= zcur;
      out_valid <= 1'b1;
      out_diff  <= d;
      out_last  <= last;
      // Flags only carry meaning on the final word; keep them at 0 otherwise.
      out_bout  <= last && b_out;
      out_z     <= last && zcur;
      out_n     <= last && d[WIDTH-1];
      out_v     <= last && (in_a[WIDTH-1] ^ in_b[WIDTH-1]) && (d[WIDTH-1] ^ in_a[WIDTH-1]);
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_bout  <= 1'b0;
      out_z     <= 1'b0;
      out_n     <= 1'b0;
      out_v     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sub_mw_seq.sv
// Self-checking bench for sub_mw_seq (WIDTH=32, WORDS=2): directed cases from the test plan,
// backpressure, reset mid-transaction, and random transactions against a full-width model.
module tb_sub_mw_seq;

  localparam int WIDTH = 32;
  localparam int WORDS = 2;
  localparam int TW    = WIDTH * WORDS;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_diff;
  logic             out_last;
  logic             out_bout;
  logic             out_z;
  logic             out_n;
  logic             out_v;

  int errors = 0;
  int checks = 0;

  sub_mw_seq #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_bin(in_bin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_diff(out_diff), .out_last(out_last),
    .out_bout(out_bout), .out_z(out_z), .out_n(out_n), .out_v(out_v)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: one full-width subtraction; words and flags are read off the wide result.
  task automatic model(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic bin,
                       output logic [TW-1:0] diff, output logic bout, output logic z,
                       output logic n, output logic v);
    logic [TW:0] full;
    full = {1'b0, a} - {1'b0, b} - (TW + 1)'(bin);
    diff = full[TW-1:0];
    bout = full[TW];
    z    = (diff == '0);
    n    = diff[TW-1];
    v    = (a[TW-1] ^ b[TW-1]) && (diff[TW-1] ^ a[TW-1]);
  endtask

  // Streams one transaction with out_ready high; in_valid is left high for back-to-back use.
  task automatic run_txn(input string tag, input logic [TW-1:0] a, input logic [TW-1:0] b,
                         input logic bin);
    logic [TW-1:0] diff;
    logic bout, z, n, v, lst;
    model(a, b, bin, diff, bout, z, n, v);
    out_ready = 1'b1;
    for (int w = 0; w < WORDS; w++) begin
      in_valid = 1'b1;
      in_a     = a[w*WIDTH +: WIDTH];
      in_b     = b[w*WIDTH +: WIDTH];
      in_bin   = (w == 0) ? bin : 1'($urandom);
      #1;
      check({tag, ".in_ready"}, 64'(in_ready), 64'(1));
      @(posedge clk);
      #1;
      lst = (w == WORDS - 1);
      check({tag, ".valid"}, 64'(out_valid), 64'(1));
      check({tag, ".diff"}, 64'(out_diff), 64'(diff[w*WIDTH +: WIDTH]));
      check({tag, ".last"}, 64'(out_last), 64'(lst));
      check({tag, ".bout"}, 64'(out_bout), 64'(lst && bout));
      check({tag, ".z"}, 64'(out_z), 64'(lst && z));
      check({tag, ".n"}, 64'(out_n), 64'(lst && n));
      check({tag, ".v"}, 64'(out_v), 64'(lst && v));
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, ".valid"}, 64'(out_valid), 64'(0));
    check({tag, ".diff"}, 64'(out_diff), 64'(0));
    check({tag, ".flags"}, 64'({out_last, out_bout, out_z, out_n, out_v}), 64'(0));
    check({tag, ".in_ready"}, 64'(in_ready), 64'(1));
  endtask

  initial begin
    logic [TW-1:0] ra, rb;
    logic [TW-1:0] bp_diff;
    logic bp_bout, bp_z, bp_n, bp_v;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_bin    = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed cases from the test plan.
    run_txn("borrow_chain", 64'h00000001_00000000, 64'h00000000_00000001, 1'b0);
    run_txn("bin_wrap", 64'h0, 64'h0, 1'b1);
    run_txn("zero", 64'h12345678_9ABCDEF0, 64'h12345678_9ABCDEF0, 1'b0);
    run_txn("low_zero_only", 64'h12345679_9ABCDEF0, 64'h12345678_9ABCDEF0, 1'b0);
    run_txn("overflow", 64'h80000000_00000000, 64'h00000000_00000001, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("drained.valid", 64'(out_valid), 64'(0));

    // Backpressure: stall 3 cycles after word 0 emerges, scrambling the unaccepted inputs.
    ra = 64'hDEADBEEF_00000005;
    rb = 64'h0BADF00D_00000007;
    model(ra, rb, 1'b0, bp_diff, bp_bout, bp_z, bp_n, bp_v);
    in_valid = 1'b1;
    in_a     = ra[WIDTH-1:0];
    in_b     = rb[WIDTH-1:0];
    in_bin   = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_a   = $urandom;
      in_b   = $urandom;
      in_bin = 1'($urandom);
      #1;
      check("bp.in_ready", 64'(in_ready), 64'(0));
      @(posedge clk);
      #1;
      check("bp.valid", 64'(out_valid), 64'(1));
      check("bp.diff_hold", 64'(out_diff), 64'(bp_diff[WIDTH-1:0]));
      check("bp.last_hold", 64'(out_last), 64'(0));
    end
    in_a      = ra[TW-1:WIDTH];
    in_b      = rb[TW-1:WIDTH];
    in_bin    = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp.word1", 64'(out_diff), 64'(bp_diff[TW-1:WIDTH]));
    check("bp.last", 64'(out_last), 64'(1));
    check("bp.flags", 64'({out_bout, out_z, out_n, out_v}), 64'({bp_bout, bp_z, bp_n, bp_v}));
    run_txn("bp_next", 64'hFFFFFFFF_FFFFFFFF, 64'h00000000_00000001, 1'b1);

    // Reset right after word 0 is accepted; the partial result is discarded.
    in_a = 32'h00000010;
    in_b = 32'h00000020;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    check_cleared("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_txn("after_reset", 64'h2, 64'h1, 1'b0);

    // Random transactions, with occasional idle gaps and equal operands.
    for (int t = 0; t < 40; t++) begin
      ra = {$urandom, $urandom};
      rb = ($urandom_range(0, 4) == 0) ? ra : {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rand.idle", 64'(out_valid), 64'(0));
      end
      run_txn("rand", ra, rb, 1'($urandom));
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
